// File: rtl/wallace_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined Wallace-tree multiplier.
interface wallace_mult_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier: Baugh-Wooley partial products, 3:2 CSA levels spread
// across PIPE_STAGES ranks, final carry-propagate add in the output rank. Global stall.
module wallace_mult_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 3
) (
  input  logic               clk,
  input  logic               rst,
  wallace_mult_pipe_if.slave bus
);

  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned NPP = WIDTH + 1;
  localparam int unsigned NRR = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  typedef logic [NPP-1:0][W2-1:0] rows_t;

  function automatic int unsigned rows_after(input int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int unsigned count_levels(input int unsigned n);
    int unsigned m;
    int unsigned l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = rows_after(m);
      l++;
    end
    return l;
  endfunction

  localparam int unsigned NLEV = count_levels(NPP);

  // First CSA level handled by rank-group k; group k covers [lvl_lo(k), lvl_lo(k+1)).
  function automatic int unsigned lvl_lo(input int unsigned k);
    return (k * NLEV) / PIPE_STAGES;
  endfunction

  // Row W carries the Baugh-Wooley correction constant (2^W + 2^(2W-1)) in signed mode.
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
    rows_t o;
    logic  bit_v;
    o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        bit_v = a[j] & b[i];
        if (s && ((i == WIDTH - 1) != (j == WIDTH - 1))) bit_v = ~bit_v;
        o[i][i+j] = bit_v;
      end
    end
    if (s) o[WIDTH] = (W2'(1) << WIDTH) | (W2'(1) << (W2 - 1));
    return o;
  endfunction

  // One 3:2 layer over the first n rows; leftover rows pass straight through.
  function automatic rows_t csa_level(input rows_t r, input int unsigned n);
    rows_t       o;
    logic [W2-1:0] x, y, z;
    int unsigned g;
    o = '0;
    g = n / 3;
    for (int unsigned i = 0; i < NPP / 3; i++) begin
      if (i < g) begin
        x = r[3*i];
        y = r[3*i+1];
        z = r[3*i+2];
        o[2*i]   = x ^ y ^ z;
        o[2*i+1] = ((x & y) | (x & z) | (y & z)) << 1;
      end
    end
    for (int unsigned j = 0; j < 2; j++) begin
      if (j < n % 3) o[2*g+j] = r[3*g+j];
    end
    return o;
  endfunction

  logic [PIPE_STAGES:0] vld_q, vld_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 sgn_q, sgn_d;
  rows_t                rows_q [NRR];
  rows_t                rows_d [NRR];
  logic [W2-1:0]        prod_q, prod_d;
  logic                 advance_c;

  always_comb begin
    rows_t       cur;
    int unsigned n;
    advance_c = !vld_q[PIPE_STAGES] || bus.out_ready;
    vld_d     = vld_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    rows_d    = rows_q;
    prod_d    = prod_q;
    n         = NPP;
    cur       = gen_pp(a_q, b_q, sgn_q);

    if (advance_c) vld_d = {vld_q[PIPE_STAGES-1:0], bus.in_valid};
    if (advance_c && bus.in_valid) begin
      a_d   = bus.a;
      b_d   = bus.b;
      sgn_d = bus.is_signed;
    end

    // Stage k reads rank k and writes rank k+1; the last stage resolves the CPA.
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      if (k > 0) cur = rows_q[(k > 0) ? k - 1 : 0];
      for (int unsigned l = 0; l < NLEV; l++) begin
        if (l >= lvl_lo(k) && l < lvl_lo(k + 1)) begin
          cur = csa_level(cur, n);
          n   = rows_after(n);
        end
      end
      if (advance_c && vld_q[k]) begin
        if (k + 1 < PIPE_STAGES) rows_d[k] = cur;
        else                     prod_d    = cur[0] + cur[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      rows_q <= '{default: '0};
      prod_q <= '0;
    end else begin
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sgn_q  <= sgn_d;
      rows_q <= rows_d;
      prod_q <= prod_d;
    end
  end

  assign bus.in_ready  = advance_c;
  assign bus.out_valid = vld_q[PIPE_STAGES];
  assign bus.product   = prod_q;
  assign bus.busy      = |vld_q;

endmodule
